// File: rtl/shiftreg_pkg.sv
// shiftreg_pkg: opcode and FSM state definitions shared by the shift register blocks
package shiftreg_pkg;
    localparam int OPW = 3;
    typedef enum logic [OPW-1:0] {
        OP_NOP  = 3'd0,
        OP_LOAD = 3'd1,
        OP_SHL  = 3'd2,
        OP_SHR  = 3'd3,
        OP_ROL  = 3'd4,
        OP_ROR  = 3'd5
    } op_e;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
    function automatic logic is_shift(input logic [OPW-1:0] op);
        return op == OP_SHL || op == OP_SHR || op == OP_ROL || op == OP_ROR;
    endfunction
endpackage

// File: rtl/shiftreg_uni_if.sv
// shiftreg_uni_if: command handshake, serial and parallel data of the shift register
interface shiftreg_uni_if import shiftreg_pkg::*; #(
    parameter int DW = 64,
    parameter int SW = 1,
    parameter int CW = $clog2(DW/SW+1)
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic [OPW-1:0] cmd_op;
    logic [CW-1:0]  cmd_count;
    logic [DW-1:0]  load_data;
    logic [SW-1:0]  sin_lo;
    logic [SW-1:0]  sin_hi;
    logic [DW-1:0]  out;
    logic [SW-1:0]  sout_lo;
    logic [SW-1:0]  sout_hi;
    logic           busy;
    logic           done;
    modport master (
        output cmd_valid, cmd_op, cmd_count, load_data, sin_lo, sin_hi,
        input  cmd_ready, out, sout_lo, sout_hi, busy, done
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_count, load_data, sin_lo, sin_hi,
        output cmd_ready, out, sout_lo, sout_hi, busy, done
    );
endinterface

// File: rtl/shiftreg_step.sv
// shiftreg_step: combinational single-step next value for shift/rotate opcodes
module shiftreg_step import shiftreg_pkg::*; #(
    parameter int DW = 64,
    parameter int SW = 1
) (
    input  logic [OPW-1:0] op,
    input  logic [DW-1:0]  cur,
    input  logic [SW-1:0]  sin_lo,
    input  logic [SW-1:0]  sin_hi,
    output logic [DW-1:0]  nxt
);
    always_comb begin
        nxt = op == OP_SHL ? {cur[DW-SW-1:0], sin_lo} :
              op == OP_SHR ? {sin_hi, cur[DW-1:SW]} :
              op == OP_ROL ? {cur[DW-SW-1:0], cur[DW-1:DW-SW]} :
              op == OP_ROR ? {cur[SW-1:0], cur[DW-1:SW]} : cur;
    end
endmodule

// File: rtl/shiftreg_uni.sv
// shiftreg_uni: universal shift register executing multi-step shift/rotate commands
module shiftreg_uni import shiftreg_pkg::*; #(
    parameter int DW = 64,
    parameter int SW = 1,
    parameter int CW = $clog2(DW/SW+1)
) (
    input logic           clk,
    input logic           rst,
    shiftreg_uni_if.slave bus
);
    state_e         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [OPW-1:0] op_q, op_n;
    logic [DW-1:0]  q, q_n, nxt;
    logic           done_q, done_n;
    logic           accept;
    assign accept = bus.cmd_valid && state == IDLE;
    shiftreg_step #(.DW(DW), .SW(SW)) u_step (
        .op     (state == RUN ? op_q : bus.cmd_op),
        .cur    (q),
        .sin_lo (bus.sin_lo),
        .sin_hi (bus.sin_hi),
        .nxt    (nxt)
    );
    // cnt holds the steps still to run after the current edge
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        op_n    = op_q;
        q_n     = q;
        done_n  = 1'b0;
        if (state == RUN) begin
            q_n   = nxt;
            cnt_n = cnt - CW'(1);
            if (cnt == CW'(1)) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
        end else if (accept) begin
            done_n = 1'b1;
            op_n   = bus.cmd_op;
            if (bus.cmd_op == OP_LOAD) q_n = bus.load_data;
            else if (is_shift(bus.cmd_op) && bus.cmd_count != '0) begin
                q_n = nxt;
                if (bus.cmd_count > CW'(1)) begin
                    state_n = RUN;
                    cnt_n   = bus.cmd_count - CW'(1);
                    done_n  = 1'b0;
                end
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= OP_NOP;
            q      <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            op_q   <= op_n;
            q      <= q_n;
            done_q <= done_n;
        end
    end
    assign bus.out       = q;
    assign bus.sout_lo   = q[SW-1:0];
    assign bus.sout_hi   = q[DW-1:DW-SW];
    assign bus.busy      = state == RUN;
    assign bus.cmd_ready = state != RUN;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_shiftreg_uni.sv
// tb_shiftreg_uni: directed table and sequence checks for shiftreg_uni at SW=1 and SW=4
module tb_shiftreg_uni;
    import shiftreg_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errs = 0;
    int checks = 0;
    always #5 clk = ~clk;

    shiftreg_uni_if #(.DW(8), .SW(1), .CW(4)) if8 ();
    shiftreg_uni_if #(.DW(8), .SW(4), .CW(2)) if4 ();
    shiftreg_uni #(.DW(8), .SW(1), .CW(4)) u8 (.clk(clk), .rst(rst), .bus(if8.slave));
    shiftreg_uni #(.DW(8), .SW(4), .CW(2)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));

    typedef struct {
        logic [2:0] op;
        logic [3:0] cnt;
        logic [7:0] data;
        logic       sl;
        logic       sh;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic [2:0] op, input logic [3:0] cnt, input logic [7:0] d,
                          input logic sl, input logic sh);
        @(negedge clk);
        if8.cmd_valid = 1'b1;
        if8.cmd_op    = op;
        if8.cmd_count = cnt;
        if8.load_data = d;
        if8.sin_lo    = sl;
        if8.sin_hi    = sh;
    endtask

    task automatic drive4(input logic [2:0] op, input logic [1:0] cnt, input logic [7:0] d,
                          input logic [3:0] sh);
        @(negedge clk);
        if4.cmd_valid = 1'b1;
        if4.cmd_op    = op;
        if4.cmd_count = cnt;
        if4.load_data = d;
        if4.sin_lo    = 4'h0;
        if4.sin_hi    = sh;
    endtask

    task automatic st8(input string nm, input logic [7:0] eo, input logic eb, input logic ed);
        chk({nm, "_out"}, if8.out, eo);
        chk({nm, "_busy"}, {7'd0, if8.busy}, {7'd0, eb});
        chk({nm, "_done"}, {7'd0, if8.done}, {7'd0, ed});
    endtask

    initial begin
        int n;
        int nb;
        logic [7:0] e;
        tbl[0]  = '{OP_LOAD, 4'd0, 8'hA5, 1'b0, 1'b0, 8'hA5};
        tbl[1]  = '{OP_SHL,  4'd1, 8'h00, 1'b1, 1'b0, 8'h4B};
        tbl[2]  = '{OP_SHR,  4'd1, 8'h00, 1'b1, 1'b0, 8'h25};
        tbl[3]  = '{OP_ROL,  4'd1, 8'h00, 1'b1, 1'b1, 8'h4A};
        tbl[4]  = '{OP_ROR,  4'd1, 8'h00, 1'b1, 1'b1, 8'h25};
        tbl[5]  = '{OP_NOP,  4'd3, 8'hFF, 1'b1, 1'b1, 8'h25};
        tbl[6]  = '{3'd7,    4'd3, 8'hFF, 1'b1, 1'b1, 8'h25};
        tbl[7]  = '{OP_SHL,  4'd0, 8'hFF, 1'b1, 1'b1, 8'h25};
        tbl[8]  = '{OP_LOAD, 4'd5, 8'h81, 1'b0, 1'b0, 8'h81};
        tbl[9]  = '{OP_ROR,  4'd1, 8'h00, 1'b0, 1'b0, 8'hC0};
        tbl[10] = '{OP_SHR,  4'd1, 8'h00, 1'b0, 1'b1, 8'hE0};
        {if8.cmd_valid, if8.cmd_op, if8.cmd_count, if8.load_data, if8.sin_lo, if8.sin_hi} = '0;
        {if4.cmd_valid, if4.cmd_op, if4.cmd_count, if4.load_data, if4.sin_lo, if4.sin_hi} = '0;
        tick();
        tick();
        st8("reset", 8'h00, 1'b0, 1'b0);
        chk("reset_ready", {7'd0, if8.cmd_ready}, 8'd1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            drive8(tbl[i].op, tbl[i].cnt, tbl[i].data, tbl[i].sl, tbl[i].sh);
            tick();
            if8.cmd_valid = 1'b0;
            e = tbl[i].exp;
            st8($sformatf("vec%0d", i), e, 1'b0, 1'b1);
            chk($sformatf("vec%0d_slo", i), {7'd0, if8.sout_lo}, {7'd0, e[0]});
            chk($sformatf("vec%0d_shi", i), {7'd0, if8.sout_hi}, {7'd0, e[7]});
        end
        tick();
        chk("done_drop", {7'd0, if8.done}, 8'd0);

        // ROL 3 from 0x81 with a LOAD held on cmd_valid throughout the run
        drive8(OP_LOAD, 4'd0, 8'h81, 1'b0, 1'b0);
        tick();
        drive8(OP_ROL, 4'd3, 8'h00, 1'b0, 1'b0);
        tick();
        if8.cmd_op    = OP_LOAD;
        if8.load_data = 8'hFF;
        st8("rol3_s1", 8'h03, 1'b1, 1'b0);
        chk("rol3_ready", {7'd0, if8.cmd_ready}, 8'd0);
        tick();
        st8("rol3_s2", 8'h06, 1'b1, 1'b0);
        tick();
        st8("rol3_s3", 8'h0C, 1'b0, 1'b1);
        tick();
        if8.cmd_valid = 1'b0;
        st8("b2b_load", 8'hFF, 1'b0, 1'b1);
        tick();
        st8("b2b_idle", 8'hFF, 1'b0, 1'b0);

        // SHL 4 with per-step serial input 1,0,1,1
        drive8(OP_LOAD, 4'd0, 8'h00, 1'b0, 1'b0);
        tick();
        drive8(OP_SHL, 4'd4, 8'h00, 1'b1, 1'b0);
        tick();
        st8("shl4_s1", 8'h01, 1'b1, 1'b0);
        if8.cmd_valid = 1'b0;
        if8.sin_lo = 1'b0;
        tick();
        st8("shl4_s2", 8'h02, 1'b1, 1'b0);
        if8.sin_lo = 1'b1;
        tick();
        st8("shl4_s3", 8'h05, 1'b1, 1'b0);
        tick();
        st8("shl4_s4", 8'h0B, 1'b0, 1'b1);
        chk("shl4_shi", {7'd0, if8.sout_hi}, 8'd0);
        chk("shl4_slo", {7'd0, if8.sout_lo}, 8'd1);

        // count beyond the register width keeps rotating
        drive8(OP_LOAD, 4'd0, 8'h81, 1'b0, 1'b0);
        tick();
        drive8(OP_ROL, 4'd10, 8'h00, 1'b0, 1'b0);
        tick();
        if8.cmd_valid = 1'b0;
        n = 0;
        nb = 0;
        while (!if8.done && n < 20) begin
            if (if8.busy) nb++;
            tick();
            n++;
        end
        chk("rol10_timeout", {7'd0, n < 20}, 8'd1);
        chk("rol10_busy", 8'(nb), 8'd9);
        st8("rol10_end", 8'h06, 1'b0, 1'b1);

        // SW=4 instance
        drive4(OP_LOAD, 2'd0, 8'h12, 4'h0);
        tick();
        drive4(OP_SHR, 2'd1, 8'h00, 4'hF);
        tick();
        chk("sw4_shr", if4.out, 8'hF1);
        chk("sw4_shr_done", {7'd0, if4.done}, 8'd1);
        chk("sw4_shi", {4'd0, if4.sout_hi}, 8'h0F);
        drive4(OP_LOAD, 2'd0, 8'h12, 4'h0);
        tick();
        drive4(OP_ROR, 2'd2, 8'h00, 4'h0);
        tick();
        if4.cmd_valid = 1'b0;
        chk("sw4_ror_s1", if4.out, 8'h21);
        chk("sw4_ror_busy", {7'd0, if4.busy}, 8'd1);
        tick();
        chk("sw4_ror_s2", if4.out, 8'h12);
        chk("sw4_ror_done", {7'd0, if4.done}, 8'd1);

        // reset mid-run aborts without done
        drive8(OP_LOAD, 4'd0, 8'h81, 1'b0, 1'b0);
        tick();
        drive8(OP_ROL, 4'd6, 8'h00, 1'b0, 1'b0);
        tick();
        if8.cmd_valid = 1'b0;
        tick();
        st8("abort_pre", 8'h06, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        st8("abort_async", 8'h00, 1'b0, 1'b0);
        tick();
        st8("abort_hold", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        if8.cmd_valid = 1'b1;
        if8.cmd_op    = OP_LOAD;
        if8.load_data = 8'h3C;
        tick();
        if8.cmd_valid = 1'b0;
        st8("post_rst_load", 8'h3C, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/shiftreg_uni.md
SHIFTREG_UNI -- requirements
Module: shiftreg_uni

Interface
REQ-001 SHALL have parameter DW, default 64: parallel register width in bits.
REQ-002 SHALL have parameter SW, default 1: bits moved per shift step; DW mod SW = 0 SHALL hold.
REQ-003 SHALL have parameter CW, default $clog2(DW/SW+1): width of the step count.
REQ-004 clk  input  1  rising-edge clock; one clock, all state on it.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at rising clk.
REQ-008 cmd_op  input  3  opcode: 0 NOP, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6-7 reserved.
REQ-009 cmd_count  input  CW  number of shift steps for ops 2-5.
REQ-010 load_data  input  DW  parallel load value.
REQ-011 sin_lo  input  SW  serial data entering bits [SW-1:0] on SHL.
REQ-012 sin_hi  input  SW  serial data entering bits [DW-1:DW-SW] on SHR.
REQ-013 out  output  DW  parallel register contents.
REQ-014 sout_lo  output  SW  equals out[SW-1:0].
REQ-015 sout_hi  output  SW  equals out[DW-1:DW-SW].
REQ-016 busy  output  1  multi-step command in progress.
REQ-017 done  output  1  one-cycle command-completion pulse.

Function
REQ-018 cmd_ready SHALL equal !busy; commands offered while busy are not accepted and SHALL have no effect.
REQ-019 FSM SHALL have two states: IDLE (busy=0) and RUN (busy=1).
REQ-020 SHL step: out <= {out[DW-SW-1:0], sin_lo}; SHR step: out <= {sin_hi, out[DW-1:SW]}.
REQ-021 ROL step: out <= {out[DW-SW-1:0], out[DW-1:DW-SW]}; ROR step: out <= {out[SW-1:0], out[DW-1:SW]}.
REQ-022 sin_lo/sin_hi SHALL be sampled at each step edge, not held from acceptance.
REQ-023 Accepted LOAD SHALL write load_data at the accept edge and ignore cmd_count.
REQ-024 Accepted shift op with count N>=1 SHALL perform step 1 at the accept edge and steps 2..N on the following N-1 edges.
REQ-025 IDLE->RUN at accept edge when N>=2; remaining counter loaded with N-1; decremented per step; RUN->IDLE at the edge performing step N.
REQ-026 Shift op with N=0, NOP and reserved ops SHALL leave out unchanged.
REQ-027 done SHALL be high exactly one cycle, in the cycle after the edge that completes the command (last step, LOAD, or zero-work accept).
REQ-028 A new command MAY be accepted in the same cycle done is high (back-to-back throughput one command per N cycles).
REQ-029 N > DW/SW SHALL be honoured literally (extra steps continue shifting/rotating), no saturation.

Reset
REQ-030 While rst high: out=0, busy=0, done=0, cmd_ready=1, counter=0, FSM=IDLE.
REQ-031 rst asserted mid-RUN SHALL abort the command immediately with no done pulse.
REQ-032 First command SHALL be acceptable at the first rising clk after rst deasserts.

Structure
REQ-033 Opcode enumeration and its width SHALL live in shared package shiftreg_pkg.
REQ-034 Single-step next-value function (op, out, sin_lo, sin_hi -> next) SHALL be combinational sub-module shiftreg_step; FSM, counter and handshake in shiftreg_uni.

Verification (DW=8, SW=1 unless stated)
REQ-035 LOAD 0xA5 -> out=0xA5 next cycle, done one cycle, busy never high.
REQ-036 LOAD 0x81, ROL N=3 -> busy 2 cycles, out=0x0C, done one cycle after final step.
REQ-037 out=0x00, SHL N=4 with sin_lo=1,0,1,1 per step -> out=0x0B; sout_hi tracks out[7].
REQ-038 DW=8, SW=4: LOAD 0x12, SHR N=1 with sin_hi=0xF -> out=0xF1; ROR N=2 from 0x12 -> 0x12.
REQ-039 SHL N=0 and op 7 -> out unchanged, done pulse; cmd_valid held during RUN -> ignored until cmd_ready.
REQ-040 rst asserted during ROL N=6 at step 3 -> out=0, busy=0, no done; next LOAD accepted first edge after release.
